// File: rtl/teclado_pkg.sv
// Shared types for the 4x4 keypad scanner: FSM states, key codes and the
// row/column to key-code map.
package teclado_pkg;

   typedef enum logic [1:0] {
      ESCANEO        = 2'd0,
      REBOTE_PULSADO = 2'd1,
      EMITIR         = 2'd2,
      ESPERA_SOLTAR  = 2'd3
   } estado_t;

   localparam logic [3:0] TEC_SUMA     = 4'hA;
   localparam logic [3:0] TEC_RESTA    = 4'hB;
   localparam logic [3:0] TEC_MULT     = 4'hC;
   localparam logic [3:0] TEC_DIV      = 4'hD;
   localparam logic [3:0] TEC_BORRAR   = 4'hE;
   localparam logic [3:0] TEC_INGRESAR = 4'hF;

   function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
      logic [3:0] cod;
      cod = 4'h0;
      case ({fila, col})
         4'h0: cod = 4'h1;
         4'h1: cod = 4'h2;
         4'h2: cod = 4'h3;
         4'h3: cod = TEC_SUMA;
         4'h4: cod = 4'h4;
         4'h5: cod = 4'h5;
         4'h6: cod = 4'h6;
         4'h7: cod = TEC_RESTA;
         4'h8: cod = 4'h7;
         4'h9: cod = 4'h8;
         4'hA: cod = 4'h9;
         4'hB: cod = TEC_MULT;
         4'hC: cod = TEC_BORRAR;
         4'hD: cod = 4'h0;
         4'hE: cod = TEC_INGRESAR;
         4'hF: cod = TEC_DIV;
      endcase
      return cod;
   endfunction

   function automatic logic es_digito(input logic [3:0] cod);
      return (cod <= 4'h9);
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; reset value is
// configurable so idle lines come out of reset at their inactive level.
module sincronizador_2ff #(
   parameter int               ANCHO       = 1,
   parameter logic [ANCHO-1:0] VALOR_RESET = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ANCHO-1:0] d,
   output logic [ANCHO-1:0] q
);

   logic [ANCHO-1:0] etapa1_q;
   logic [ANCHO-1:0] etapa2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         etapa1_q <= VALOR_RESET;
         etapa2_q <= VALOR_RESET;
      end else begin
         etapa1_q <= d;
         etapa2_q <= etapa1_q;
      end
   end

   assign q = etapa2_q;

endmodule

// File: rtl/teclado_matricial_4x4.sv
// 4x4 keypad scanner with row debouncing and per-class key strobes.
// Optional digit auto-repeat is enabled by defining TECLADO_AUTOREPEAT_EN.
module teclado_matricial_4x4
   import teclado_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CYC = 200000,
   parameter int REPEAT_CYC   = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] filas,
   output logic [3:0] columnas,
   output logic [3:0] tecla,
   output logic       numero_en,
   output logic       operacion_en,
   output logic       ingresar_en,
   output logic       borrar_en
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DIV_W-1:0] DIV_ULT = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_ULT = DEB_W'(DEBOUNCE_CYC - 1);

   if (SCAN_DIV < 4) begin : g_chk_div
      $error("SCAN_DIV must be at least 4");
   end
   if (DEBOUNCE_CYC < 1) begin : g_chk_deb
      $error("DEBOUNCE_CYC must be at least 1");
   end
   if (REPEAT_CYC < 1) begin : g_chk_rep
      $error("REPEAT_CYC must be at least 1");
   end

   function automatic logic una_fila_baja(input logic [3:0] p);
      return ($countones(~p) == 1);
   endfunction

   function automatic logic [1:0] indice_fila(input logic [3:0] p);
      logic [1:0] idx;
      idx = 2'd0;
      case (p)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   logic [3:0] filas_s;

   sincronizador_2ff #(
      .ANCHO       (4),
      .VALOR_RESET (4'hF)
   ) u_sinc_filas (
      .clk   (clk),
      .reset (reset),
      .d     (filas),
      .q     (filas_s)
   );

   estado_t          estado_q, estado_d;
   logic [1:0]       col_q, col_d;
   logic [3:0]       columnas_q, columnas_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic [3:0]       patron_q, patron_d;
   logic [1:0]       fila_q, fila_d;
   logic [3:0]       tecla_q, tecla_d;
   logic             numero_q, numero_d;
   logic             operacion_q, operacion_d;
   logic             ingresar_q, ingresar_d;
   logic             borrar_q, borrar_d;
   logic [3:0]       codigo;

`ifdef TECLADO_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYC + 1);
   localparam logic [REP_W-1:0] REP_ULT = REP_W'(REPEAT_CYC - 1);
   logic [REP_W-1:0] rep_q, rep_d;
`endif

   assign codigo = codigo_tecla(fila_q, col_q);

   always_comb begin
      estado_d    = estado_q;
      col_d       = col_q;
      div_d       = div_q;
      deb_d       = deb_q;
      patron_d    = patron_q;
      fila_d      = fila_q;
      tecla_d     = tecla_q;
      numero_d    = 1'b0;
      operacion_d = 1'b0;
      ingresar_d  = 1'b0;
      borrar_d    = 1'b0;
`ifdef TECLADO_AUTOREPEAT_EN
      rep_d       = rep_q;
`endif
      case (estado_q)
         ESCANEO: begin
            if (div_q == DIV_ULT) begin
               div_d = '0;
               // Zero or several rows low (ghosting) never latch a key.
               if (una_fila_baja(filas_s)) begin
                  patron_d = filas_s;
                  fila_d   = indice_fila(filas_s);
                  deb_d    = '0;
                  estado_d = REBOTE_PULSADO;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         REBOTE_PULSADO: begin
            if (filas_s != patron_q) begin
               estado_d = ESCANEO;
               div_d    = '0;
               deb_d    = '0;
            end else if (deb_q == DEB_ULT) begin
               estado_d    = EMITIR;
               deb_d       = '0;
               tecla_d     = codigo;
               numero_d    = es_digito(codigo);
               operacion_d = (codigo >= TEC_SUMA) && (codigo <= TEC_DIV);
               borrar_d    = (codigo == TEC_BORRAR);
               ingresar_d  = (codigo == TEC_INGRESAR);
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         EMITIR: begin
            estado_d = ESPERA_SOLTAR;
            deb_d    = '0;
`ifdef TECLADO_AUTOREPEAT_EN
            rep_d    = '0;
`endif
         end
         ESPERA_SOLTAR: begin
            if (filas_s == 4'hF) begin
               if (deb_q == DEB_ULT) begin
                  estado_d = ESCANEO;
                  deb_d    = '0;
                  div_d    = '0;
                  col_d    = col_q + 2'd1;
               end else begin
                  deb_d = deb_q + DEB_W'(1);
               end
            end else begin
               deb_d = '0;
            end
`ifdef TECLADO_AUTOREPEAT_EN
            // Non-digit keys park the counter at its last value and never repeat.
            if (filas_s == patron_q) begin
               if (rep_q == REP_ULT) begin
                  if (es_digito(tecla_q)) begin
                     rep_d    = '0;
                     numero_d = 1'b1;
                  end
               end else begin
                  rep_d = rep_q + REP_W'(1);
               end
            end else begin
               rep_d = '0;
            end
`endif
         end
      endcase
      columnas_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q    <= ESCANEO;
         col_q       <= 2'd0;
         columnas_q  <= 4'b1110;
         div_q       <= '0;
         deb_q       <= '0;
         patron_q    <= 4'hF;
         fila_q      <= 2'd0;
         tecla_q     <= 4'h0;
         numero_q    <= 1'b0;
         operacion_q <= 1'b0;
         ingresar_q  <= 1'b0;
         borrar_q    <= 1'b0;
`ifdef TECLADO_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         estado_q    <= estado_d;
         col_q       <= col_d;
         columnas_q  <= columnas_d;
         div_q       <= div_d;
         deb_q       <= deb_d;
         patron_q    <= patron_d;
         fila_q      <= fila_d;
         tecla_q     <= tecla_d;
         numero_q    <= numero_d;
         operacion_q <= operacion_d;
         ingresar_q  <= ingresar_d;
         borrar_q    <= borrar_d;
`ifdef TECLADO_AUTOREPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign columnas     = columnas_q;
   assign tecla        = tecla_q;
   assign numero_en    = numero_q;
   assign operacion_en = operacion_q;
   assign ingresar_en  = ingresar_q;
   assign borrar_en    = borrar_q;

endmodule

// File: tb/tb_teclado_matricial_4x4.sv
// Directed bench for teclado_matricial_4x4 with a behavioural keypad matrix;
// the auto-repeat scenario follows TECLADO_AUTOREPEAT_EN.
module tb_teclado_matricial_4x4;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CYC = 8;
   localparam int REPEAT_CYC   = 40;
   localparam int LAT_MAX      = 2 + 4*SCAN_DIV + DEBOUNCE_CYC + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] filas;
   logic [3:0] columnas;
   logic [3:0] tecla;
   logic       numero_en, operacion_en, ingresar_en, borrar_en;

   logic [15:0] pulsadas = 16'h0;
   logic [3:0]  rebote_alto = 4'h0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_num = 0, n_op = 0, n_ing = 0, n_bor = 0;
   int n_multi = 0, n_ancho = 0, t_ult = 0;
   bit previo = 1'b0;

   teclado_matricial_4x4 #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .filas        (filas),
      .columnas     (columnas),
      .tecla        (tecla),
      .numero_en    (numero_en),
      .operacion_en (operacion_en),
      .ingresar_en  (ingresar_en),
      .borrar_en    (borrar_en)
   );

   always #5 clk = ~clk;

   // Passive matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      filas = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!columnas[c] && pulsadas[r*4+c]) filas[r] = 1'b0;
      filas = filas | rebote_alto;
   end

   always @(posedge clk) begin
      int suma;
      #1;
      cyc++;
      suma = int'(numero_en) + int'(operacion_en) + int'(ingresar_en) + int'(borrar_en);
      if (numero_en)    n_num++;
      if (operacion_en) n_op++;
      if (ingresar_en)  n_ing++;
      if (borrar_en)    n_bor++;
      if (suma > 1) n_multi++;
      if (suma > 0 && previo) n_ancho++;
      if (suma > 0) t_ult = cyc;
      previo = (suma > 0);
   end

   function automatic int n_total();
      return n_num + n_op + n_ing + n_bor;
   endfunction

   function automatic int idx(input int r, input int c);
      return r*4 + c;
   endfunction

   task automatic ciclos(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic esperar_strobe(input int base, input int limite, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limite; i++) begin
         @(negedge clk);
         if (n_total() != base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ciclos(3);
      total++;
      if (columnas !== 4'b1110) begin
         bad++; $display("FAIL reset_columnas: got %b expected %b", columnas, 4'b1110);
      end
      total++;
      if (tecla !== 4'h0) begin
         bad++; $display("FAIL reset_tecla: got %h expected 0", tecla);
      end
      total++;
      if ({numero_en, operacion_en, ingresar_en, borrar_en} !== 4'b0000) begin
         bad++; $display("FAIL reset_strobes: got %b expected 0000",
                         {numero_en, operacion_en, ingresar_en, borrar_en});
      end
   endtask

   task automatic test_escaneo();
      logic [3:0] uno, esperado;
      logic [1:0] sh;
      uno = 4'b0001;
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         sh = 2'((k / 4) % 4);
         esperado = ~(uno << sh);
         total++;
         if (columnas !== esperado) begin
            bad++; $display("FAIL escaneo_k%0d: got %b expected %b", k, columnas, esperado);
         end
         if (k == 1) begin
            total++;
            if ({numero_en, operacion_en, ingresar_en, borrar_en} !== 4'b0000) begin
               bad++; $display("FAIL strobe_tras_reset: got %b expected 0000",
                               {numero_en, operacion_en, ingresar_en, borrar_en});
            end
         end
      end
      ciclos(80);
      total++;
      if (n_total() != 0) begin
         bad++; $display("FAIL escaneo_sin_strobe: got %0d expected 0", n_total());
      end
   endtask

   task automatic test_tecla_5();
      int base, nb;
      base = n_total();
      nb = n_num;
      pulsadas[idx(1, 1)] = 1'b1;
      ciclos(30);
      pulsadas = 16'h0;
      ciclos(30);
      total++;
      if (n_num - nb != 1) begin
         bad++; $display("FAIL tecla5_numero_en: got %0d expected 1", n_num - nb);
      end
      total++;
      if (tecla !== 4'h5) begin
         bad++; $display("FAIL tecla5_codigo: got %h expected 5", tecla);
      end
      ciclos(40);
      total++;
      if (n_total() - base != 1) begin
         bad++; $display("FAIL tecla5_una_vez: got %0d expected 1", n_total() - base);
      end
   endtask

   task automatic test_rebote_ingresar();
      int base, ni, t0;
      bit ok;
      base = n_total();
      ni = n_ing;
      pulsadas[idx(3, 2)] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rebote_alto = (i % 2 == 1) ? 4'b1000 : 4'b0000;
         ciclos(3);
      end
      total++;
      if (n_total() != base) begin
         bad++; $display("FAIL rebote_prematuro: got %0d expected %0d", n_total(), base);
      end
      rebote_alto = 4'h0;
      t0 = cyc;
      esperar_strobe(base, LAT_MAX + 5, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL rebote_timeout: got none expected ingresar_en");
      end
      total++;
      if (t_ult - t0 > LAT_MAX) begin
         bad++; $display("FAIL rebote_latencia: got %0d expected <= %0d", t_ult - t0, LAT_MAX);
      end
      ciclos(10);
      total++;
      if (n_ing - ni != 1 || n_total() - base != 1) begin
         bad++; $display("FAIL rebote_ingresar_en: got %0d/%0d expected 1/1",
                         n_ing - ni, n_total() - base);
      end
      total++;
      if (tecla !== 4'hF) begin
         bad++; $display("FAIL rebote_codigo: got %h expected f", tecla);
      end
      pulsadas = 16'h0;
      ciclos(30);
   endtask

   task automatic test_fantasma();
      int base;
      logic [3:0] vistos;
      base = n_total();
      vistos = 4'h0;
      pulsadas[idx(0, 0)] = 1'b1;
      pulsadas[idx(2, 0)] = 1'b1;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         vistos = vistos | ~columnas;
      end
      total++;
      if (vistos !== 4'hF) begin
         bad++; $display("FAIL fantasma_rotacion: got %b expected 1111", vistos);
      end
      total++;
      if (n_total() != base) begin
         bad++; $display("FAIL fantasma_strobe: got %0d expected %0d", n_total(), base);
      end
      pulsadas = 16'h0;
      ciclos(5);
   endtask

   task automatic esperar_columnas(input logic [3:0] objetivo, input string nombre);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (columnas === objetivo) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++; $display("FAIL %s: got %b expected %b", nombre, columnas, objetivo);
      end
   endtask

   task automatic test_reset_en_rebote();
      int no_;
      bit ok;
      no_ = n_op;
      esperar_columnas(4'b1011, "espera_col2");
      pulsadas[idx(0, 3)] = 1'b1;
      esperar_columnas(4'b0111, "espera_col3");
      ciclos(6);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (columnas !== 4'b1110 || tecla !== 4'h0 || operacion_en !== 1'b0) begin
         bad++; $display("FAIL reset_rebote: got col=%b tecla=%h op=%b expected 1110/0/0",
                         columnas, tecla, operacion_en);
      end
      pulsadas = 16'h0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (n_op != no_ || operacion_en !== 1'b0) begin
         bad++; $display("FAIL reset_rebote_sin_op: got %0d expected %0d", n_op - no_, 0);
      end
      pulsadas[idx(0, 3)] = 1'b1;
      esperar_strobe(n_total(), LAT_MAX + 5, ok);
      total++;
      if (!ok || tecla !== 4'hA || operacion_en !== 1'b1 || n_op - no_ != 1) begin
         bad++; $display("FAIL represion_A: got ok=%0d tecla=%h op=%b n=%0d expected 1/a/1/1",
                         ok, tecla, operacion_en, n_op - no_);
      end
      ciclos(12);
      pulsadas = 16'h0;
      ciclos(30);
   endtask

   task automatic test_segunda_tecla();
      int base;
      bit ok;
      base = n_total();
      pulsadas[idx(1, 1)] = 1'b1;
      esperar_strobe(base, LAT_MAX + 5, ok);
      pulsadas[idx(2, 2)] = 1'b1;
      ciclos(15);
      pulsadas[idx(2, 2)] = 1'b0;
      ciclos(5);
      pulsadas = 16'h0;
      ciclos(30);
      total++;
      if (!ok || n_total() - base != 1 || tecla !== 4'h5) begin
         bad++; $display("FAIL segunda_tecla: got ok=%0d n=%0d tecla=%h expected 1/1/5",
                         ok, n_total() - base, tecla);
      end
   endtask

   task automatic test_repeticion();
      int base, nb, no_, k, t_a;
      bit ok;
`ifdef TECLADO_AUTOREPEAT_EN
      int t1, t2;
      t1 = 0;
      t2 = 0;
`endif
      nb = n_num;
      base = n_total();
      pulsadas[idx(2, 0)] = 1'b1;
      esperar_strobe(base, LAT_MAX + 5, ok);
      t_a = t_ult;
      k = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (numero_en) begin
            k++;
`ifdef TECLADO_AUTOREPEAT_EN
            if (k == 1) t1 = cyc;
            if (k == 2) t2 = cyc;
`endif
         end
      end
      total++;
      if (!ok || tecla !== 4'h7) begin
         bad++; $display("FAIL rep7_codigo: got ok=%0d tecla=%h expected 1/7", ok, tecla);
      end
`ifdef TECLADO_AUTOREPEAT_EN
      total++;
      if (k != 2 || n_num - nb != 3) begin
         bad++; $display("FAIL rep7_cuenta: got %0d/%0d expected 2/3", k, n_num - nb);
      end
      total++;
      if (t1 - t_a < REPEAT_CYC - 1 || t1 - t_a > REPEAT_CYC + 2 ||
          t2 - t1 < REPEAT_CYC - 1 || t2 - t1 > REPEAT_CYC + 2) begin
         bad++; $display("FAIL rep7_intervalo: got %0d,%0d expected about %0d",
                         t1 - t_a, t2 - t1, REPEAT_CYC);
      end
`else
      total++;
      if (k != 0 || n_num - nb != 1) begin
         bad++; $display("FAIL rep7_unico: got %0d/%0d expected 0/1", k, n_num - nb);
      end
      total++;
      if (t_ult != t_a) begin
         bad++; $display("FAIL rep7_sin_repeticion: got %0d expected %0d", t_ult, t_a);
      end
`endif
      pulsadas = 16'h0;
      ciclos(30);
      no_ = n_op;
      base = n_total();
      pulsadas[idx(3, 3)] = 1'b1;
      esperar_strobe(base, LAT_MAX + 5, ok);
      ciclos(100);
      total++;
      if (!ok || n_op - no_ != 1 || n_total() - base != 1 || tecla !== 4'hD) begin
         bad++; $display("FAIL repD_unico: got ok=%0d op=%0d tot=%0d tecla=%h expected 1/1/1/d",
                         ok, n_op - no_, n_total() - base, tecla);
      end
      pulsadas = 16'h0;
      ciclos(30);
   endtask

   task automatic test_exclusion();
      total++;
      if (n_multi != 0) begin
         bad++; $display("FAIL strobes_exclusivos: got %0d expected 0", n_multi);
      end
      total++;
      if (n_ancho != 0) begin
         bad++; $display("FAIL strobe_un_ciclo: got %0d expected 0", n_ancho);
      end
      total++;
      if (n_bor != 0) begin
         bad++; $display("FAIL borrar_espurio: got %0d expected 0", n_bor);
      end
   endtask

   initial begin
      test_reset();
      test_escaneo();
      test_tecla_5();
      test_rebote_ingresar();
      test_fantasma();
      test_reset_en_rebote();
      test_segunda_tecla();
      test_repeticion();
      test_exclusion();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1);
   end

endmodule

// File: doc/teclado_matricial_4x4.md
Name: teclado_matricial_4x4

Overview:
- Scans a 4x4 membrane keypad, synchronises and debounces the row lines, and emits one registered key code per physical press.
- Classifies each key as digit, operator, enter or clear, and pulses the matching one-cycle strobe.
- It is the producer side of the calculator's key interface. Its `numero_en` / `operacion_en` / `ingresar_en` / `borrar_en` strobes and `tecla` code feed the number-entry and operand FSMs directly.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is held active before rotating (min 4).
- DEBOUNCE_CYC, 200000, consecutive clk cycles a row pattern must stay stable for both press and release.
- REPEAT_CYC, 25000000, hold time before auto-repeat. Only used with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- filas  in  4  keypad row lines; asynchronous; active-low with external pull-ups.
- columnas  out  4  column drive; exactly one bit low (active), the others high.
- tecla  out  4  code of the last accepted key; held until the next accept.
- numero_en  out  1  one-cycle strobe: accepted key is a digit (code 0x0-0x9).
- operacion_en  out  1  one-cycle strobe: key A/B/C/D (0xA-0xD = + - x /).
- ingresar_en  out  1  one-cycle strobe: key # (0xF, enter).
- borrar_en  out  1  one-cycle strobe: key * (0xE, clear).

Behaviour:
- Reset is synchronous, active-high, clock clk. It has priority in any state, including mid-debounce or mid-release.
  - Values after reset: state=ESCANEO, columnas=4'b1110, tecla=4'h0, all strobes 0, all counters 0.
  - No strobe is asserted in the reset cycle or in the cycle after it.
- Input sync: filas passes through a 2-flop synchroniser. All decisions use the synchronised value `filas_s`.
- Key map (row r, column c), codes:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Counter widths: division counter $clog2(SCAN_DIV); debounce counter $clog2(DEBOUNCE_CYC+1). Counters saturate; they never wrap.
- States:
  - ESCANEO
    - The column is held for SCAN_DIV cycles.
    - On the last cycle, if `filas_s` has exactly one bit low: latch the column index and the row pattern, and go to REBOTE_PULSADO. The column stays frozen.
    - Otherwise (including 0 or 2+ rows low, i.e. ghosting/multi-key): rotate to the next column, wrapping col3 to col0.
  - REBOTE_PULSADO
    - Counts up while `filas_s` equals the latched pattern.
    - Any mismatch: back to ESCANEO on the same column, with the divider cleared. No output.
    - Count reaches DEBOUNCE_CYC: go to EMITIR.
  - EMITIR (1 cycle)
    - `tecla` <= code, and exactly one strobe is asserted for this single cycle.
    - Next state is ESPERA_SOLTAR.
  - ESPERA_SOLTAR
    - Column stays frozen.
    - Counts up while `filas_s` = 4'hF; any low bit clears the count.
    - Count reaches DEBOUNCE_CYC: go to ESCANEO on the next column.
- Output timing: strobes and `tecla` are registered and change in the same edge. The strobes are mutually exclusive.
- Latency from a clean press to the strobe: 2 (sync) + at most 4*SCAN_DIV + DEBOUNCE_CYC + 1 cycles.
- One press gives exactly one strobe, however long it is held (unless the optional feature is enabled).
- A second key pressed while in ESPERA_SOLTAR is ignored until all keys are released.

Optional Feature:
- Macro: TECLADO_AUTOREPEAT_EN.
- Defined:
  - In ESPERA_SOLTAR, a repeat counter runs while the latched pattern stays held. It is cleared on any pattern change.
  - When it reaches REPEAT_CYC for a digit key: re-emit the same `tecla` and numero_en for one cycle, clear the counter, and repeat again every REPEAT_CYC cycles.
  - Operator, enter and clear keys never repeat.
- Undefined: no repeat counter is built, and REPEAT_CYC is ignored.

Decomposition:
- Package teclado_pkg holds:
  - the state encodings: ESCANEO, REBOTE_PULSADO, EMITIR, ESPERA_SOLTAR;
  - the key-code constants: TEC_SUMA=4'hA, TEC_RESTA=4'hB, TEC_MULT=4'hC, TEC_DIV=4'hD, TEC_BORRAR=4'hE, TEC_INGRESAR=4'hF;
  - the 16-entry row/column-to-code map function.
- Sub-module sincronizador_2ff (width parameter) for `filas`; reusable elsewhere.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=40):
- Reset release with filas=4'hF held for 100 cycles → columnas cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; no strobe.
- Key '5' (row1 low while col1 active), held 30 cycles, then released cleanly → exactly one numero_en; tecla=4'h5; next strobe only after a new press.
- Key '#' bounces (row3 toggles every 3 cycles for 12 cycles, then stable low) → single ingresar_en, tecla=4'hF, within 2+16+8+1 cycles of becoming stable.
- Rows 0 and 2 low simultaneously on col0 → no strobe; the scan keeps rotating.
- reset asserted during REBOTE_PULSADO of key 'A' → next cycle: columnas=1110, tecla=0, no operacion_en; after reset is released, a re-press gives tecla=4'hA with operacion_en.
- With TECLADO_AUTOREPEAT_EN, '7' held 100 cycles → numero_en at accept and about +40, +80 cycles later; with 'D' held the same time → a single operacion_en.
